pll_reconfig_seq: RTL and testbench

- Management-side sequencer for the Cyclone V reconfigurable PLL wrapper (one 48 MHz output, fractional VCO).
- Drives the Avalon-MM management port of the PLL reconfiguration core, whose 64-bit reconfig_to_pll/reconfig_from_pll bus connects to the PLL.
- Replays a loaded table of (register address, data) writes, triggers reconfiguration, and waits for the PLL to relock.
- Runs on the 50 MHz reference clock and lets the core retune the pixel/CPU clock at runtime.

---
 rtl/pll_reconfig_pkg.sv | 34 +++
 rtl/pll_reconfig_table.sv | 24 ++
 rtl/pll_reconfig_seq.sv | 204 ++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types and reconfig register map for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_MODE   = 6'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS = 6'h01;
  localparam logic [ADDR_W-1:0] REG_START  = 6'h02;
  localparam logic [ADDR_W-1:0] REG_N_CNT  = 6'h03;
  localparam logic [ADDR_W-1:0] REG_M_CNT  = 6'h04;
  localparam logic [ADDR_W-1:0] REG_C_CNT  = 6'h05;
  localparam logic [ADDR_W-1:0] REG_DPS    = 6'h06;
  localparam logic [ADDR_W-1:0] REG_M_FRAC = 6'h07;
  localparam logic [ADDR_W-1:0] REG_BW     = 6'h08;
  localparam logic [ADDR_W-1:0] REG_CP     = 6'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_ENTRY,
    ST_START,
    ST_WAIT_RC,
    ST_SETTLE,
    ST_LOCK,
    ST_FIN
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } tbl_entry_t;

endpackage

// File: rtl/pll_reconfig_table.sv
// Write table: one synchronous write port, one combinational read port, not reset.
module pll_reconfig_table
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned TABLE_DEPTH = 16,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  tbl_entry_t       wr_entry,
  input  logic [IDX_W-1:0] rd_idx,
  output tbl_entry_t       rd_entry_c
);

  tbl_entry_t mem_q [TABLE_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_idx] <= wr_entry;
  end

  assign rd_entry_c = mem_q[rd_idx];

endmodule

// File: rtl/pll_reconfig_seq.sv
// Replays a (addr, data) table into the PLL reconfig core over Avalon-MM,
// triggers reconfiguration and waits for a stable relock, with a watchdog.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned TABLE_DEPTH    = 16,
  parameter int unsigned IDX_W          = 4,
  parameter int unsigned LOCK_SETTLE    = 64,
  parameter int unsigned LOCK_STABLE    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [5:0]        cfg_addr,
  input  logic [31:0]       cfg_data,
  input  logic [IDX_W:0]    cfg_count,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [5:0]        mgmt_address,
  output logic [31:0]       mgmt_writedata,
  output logic              mgmt_write,
  input  logic              mgmt_waitrequest,
  input  logic              pll_locked
);

  localparam int unsigned NW    = IDX_W + 1;
  localparam int unsigned CMAX  = (LOCK_SETTLE > LOCK_STABLE) ? LOCK_SETTLE : LOCK_STABLE;
  localparam int unsigned CNT_W = $clog2(CMAX + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e        state_q, state_d;
  logic [NW-1:0]     n_q, n_d, i_q, i_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              wr_q, wr_d;
  logic [5:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              lock_s1_q, lock_s2_q;
  logic              tbl_we_c, xfer_c;
  tbl_entry_t        tbl_rd_c;

  pll_reconfig_table #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk        (refclk),
    .we         (tbl_we_c),
    .wr_idx     (cfg_idx),
    .wr_entry   ({cfg_addr, cfg_data}),
    .rd_idx     (i_q[IDX_W-1:0]),
    .rd_entry_c (tbl_rd_c)
  );

  // Next-state and registered-output logic; each write state issues once, then waits.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    done_d   = 1'b0;
    error_d  = error_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tbl_we_c = 1'b0;
    xfer_c   = wr_q && !mgmt_waitrequest;

    if (state_q != ST_IDLE) wd_d = wd_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tbl_we_c = cfg_we;
        if (go) begin
          state_d = ST_MODE;
          n_d     = (cfg_count > NW'(TABLE_DEPTH)) ? NW'(TABLE_DEPTH) : cfg_count;
          i_d     = '0;
          error_d = 1'b0;
          wd_d    = '0;
        end
      end
      ST_MODE: begin
        if (!wr_q) begin
          wr_d   = 1'b1;
          addr_d = REG_MODE;
          data_d = 32'h0;
        end else if (xfer_c) begin
          wr_d    = 1'b0;
          state_d = (n_q == '0) ? ST_START : ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (i_q == n_q) begin
          state_d = ST_START;
        end else if (!wr_q) begin
          wr_d   = 1'b1;
          addr_d = tbl_rd_c.addr;
          data_d = tbl_rd_c.data;
        end else if (xfer_c) begin
          wr_d = 1'b0;
          i_d  = i_q + 1'b1;
          if ((i_q + 1'b1) == n_q) state_d = ST_START;
        end
      end
      ST_START: begin
        if (!wr_q) begin
          wr_d   = 1'b1;
          addr_d = REG_START;
          data_d = 32'h0;
        end else if (xfer_c) begin
          wr_d    = 1'b0;
          state_d = ST_WAIT_RC;
        end
      end
      ST_WAIT_RC: begin
        // The core stalls this status write until reconfiguration finishes.
        if (!wr_q) begin
          wr_d   = 1'b1;
          addr_d = REG_STATUS;
          data_d = 32'h0;
        end else if (xfer_c) begin
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(LOCK_SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOCK: begin
        if (!lock_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Watchdog overrides everything, including a completing transfer.
    if (state_q != ST_IDLE && wd_d == WD_W'(TIMEOUT_CYCLES)) begin
      state_d = ST_IDLE;
      wr_d    = 1'b0;
      error_d = 1'b1;
      done_d  = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      i_q       <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      i_q       <= i_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mgmt_write     = wr_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: table-driven sequence runs plus lock, timeout and reset corners.
module tb_pll_reconfig_seq;
  import pll_reconfig_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 4;
  localparam int unsigned LS    = 64;
  localparam int unsigned LST   = 16;
  localparam int unsigned TO    = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [5:0]    cfg_addr = '0;
  logic [31:0]   cfg_data = '0;
  logic [IW:0]   cfg_count = '0;
  logic          go = 1'b0;
  logic          busy, done, error;
  logic [5:0]    mgmt_address;
  logic [31:0]   mgmt_writedata;
  logic          mgmt_write;
  logic          mgmt_waitrequest = 1'b0;
  logic          pll_locked = 1'b1;

  always #5 clk = ~clk;

  pll_reconfig_seq #(
    .TABLE_DEPTH    (DEPTH),
    .IDX_W          (IW),
    .LOCK_SETTLE    (LS),
    .LOCK_STABLE    (LST),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .refclk           (clk),
    .rst              (rst),
    .cfg_we           (cfg_we),
    .cfg_idx          (cfg_idx),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .cfg_count        (cfg_count),
    .go               (go),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_write       (mgmt_write),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t log_q[$];
  wr_t exp_tbl [DEPTH];

  typedef struct {
    string name;
    int    cnt;
    bit    stall;
    int    exp_lat;
  } vec_t;

  bit stall_en  = 1'b0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Avalon slave model: when enabled, stall every write for 5 cycles.
  always @(posedge clk) begin
    #1;
    if (stall_en && mgmt_write) begin
      if (stall_cnt < 5) begin
        mgmt_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        mgmt_waitrequest = 1'b0;
      end
    end else begin
      mgmt_waitrequest = stall_en;
      stall_cnt = 0;
    end
  end

  // Log completed transfers and check address/data hold during stalls.
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_a = '0;
  logic [31:0] prev_d = '0;
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      checks++;
      if (!(mgmt_write && mgmt_address == prev_a && mgmt_writedata == prev_d)) begin
        errors++;
        $display("FAIL stall_hold: got wr=%0b a=%0h d=%0h expected wr=1 a=%0h d=%0h",
                 mgmt_write, mgmt_address, mgmt_writedata, prev_a, prev_d);
      end
    end
    if (!rst && mgmt_write && !mgmt_waitrequest) log_q.push_back({mgmt_address, mgmt_writedata});
    prev_stall = !rst && mgmt_write && mgmt_waitrequest;
    prev_a     = mgmt_address;
    prev_d     = mgmt_writedata;
  end

  function automatic wr_t exp_write(input int n, input int i);
    if (i == 0) return {REG_MODE, 32'h0};
    if (i <= n) return exp_tbl[i-1];
    if (i == n + 1) return {REG_START, 32'h0};
    return {REG_STATUS, 32'h0};
  endfunction

  task automatic run_seq(input string name, input int cnt, input bit stall, input int exp_lat, input bit inject);
    int  n;
    int  k;
    bit  got;
    bit  busy_ok;
    wr_t w;
    n = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
    log_q.delete();
    stall_en = stall;
    @(posedge clk); #1;
    cfg_count = (IW+1)'(cnt);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    #1;
    chk({name, "_err_clr"}, 64'(error), 64'd0);
    got = 1'b0; busy_ok = 1'b1; k = 0;
    for (int c = 1; c <= 2000 && !got; c++) begin
      @(posedge clk); #1;
      if (inject && c == 5) begin
        go = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_addr = 6'h3F;
        cfg_data = 32'hDEAD_BEEF; cfg_count = 5'd1;
      end
      if (inject && c == 6) begin
        go = 1'b0; cfg_we = 1'b0;
      end
      #1;
      if (done) begin
        got = 1'b1; k = c;
        chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
        chk({name, "_err"}, 64'(error), 64'd0);
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    chk({name, "_latency"}, 64'(k), 64'(exp_lat));
    chk({name, "_busy_held"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #2;
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
    chk({name, "_busy_fall"}, 64'(busy), 64'd0);
    chk({name, "_nwrites"}, 64'(log_q.size()), 64'(n + 3));
    for (int i = 0; i < n + 3 && i < log_q.size(); i++) begin
      w = exp_write(n, i);
      chk($sformatf("%s_wr%0d", name, i), 64'(log_q[i]), 64'(w));
    end
    stall_en = 1'b0;
  endtask

  initial begin
    vec_t vecs [7];
    int   k;
    bit   got;

    vecs[0] = '{"n3",       3,  1'b0, 92};
    vecs[1] = '{"n3_stall", 3,  1'b1, 122};
    vecs[2] = '{"n0",       0,  1'b0, 86};
    vecs[3] = '{"n20",      20, 1'b0, 118};
    vecs[4] = '{"n16",      16, 1'b0, 118};
    vecs[5] = '{"n1_stall", 1,  1'b1, 108};
    vecs[6] = '{"n7",       7,  1'b0, 100};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy",  64'(busy),           64'd0);
    chk("rst_done",  64'(done),           64'd0);
    chk("rst_error", 64'(error),          64'd0);
    chk("rst_write", 64'(mgmt_write),     64'd0);
    chk("rst_addr",  64'(mgmt_address),   64'd0);
    chk("rst_data",  64'(mgmt_writedata), 64'd0);
    rst = 1'b0;

    exp_tbl[0] = {6'h04, 32'h0000_0404};
    exp_tbl[1] = {6'h07, 32'hA3D7_0A3D};
    exp_tbl[2] = {6'h05, 32'h0005_0504};
    for (int i = 3; i < int'(DEPTH); i++) exp_tbl[i] = {6'(3 + (i % 7)), 32'hC0DE_0000 | 32'(i)};
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_idx = IW'(i); cfg_addr = exp_tbl[i].a; cfg_data = exp_tbl[i].d;
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;

    for (int v = 0; v < 7; v++) run_seq(vecs[v].name, vecs[v].cnt, vecs[v].stall, vecs[v].exp_lat, 1'b0);

    // go and cfg_we while busy are ignored; entry 0 must still hold its original value.
    run_seq("busy_inject", 3, 1'b0, 92, 1'b1);
    run_seq("after_inject", 1, 1'b0, 88, 1'b0);

    // Lock drop after 12 good samples, low for 10 samples, then 16 more needed.
    pll_locked = 1'b1;
    @(posedge clk); #1;
    cfg_count = '0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    got = 1'b0; k = 0;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 80) pll_locked = 1'b0;
      if (c == 90) pll_locked = 1'b1;
      #1;
      if (done) begin got = 1'b1; k = c; end
    end
    chk("lockdrop_latency", 64'(k), 64'd108);

    // Watchdog: locked never asserts.
    pll_locked = 1'b0;
    @(posedge clk); #1;
    cfg_count = '0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    got = 1'b0; k = 0;
    for (int c = 1; c <= 1200 && !got; c++) begin
      @(posedge clk); #2;
      if (done) begin
        got = 1'b1; k = c;
        chk("to_error", 64'(error), 64'd1);
        chk("to_write", 64'(mgmt_write), 64'd0);
      end
    end
    chk("to_latency", 64'(k), 64'(TO));
    repeat (5) @(posedge clk);
    #2;
    chk("to_error_sticky", 64'(error), 64'd1);
    chk("to_done_low", 64'(done), 64'd0);
    chk("to_busy_low", 64'(busy), 64'd0);
    pll_locked = 1'b1;
    run_seq("after_to", 0, 1'b0, 86, 1'b0);

    // Reset while a write is stalled.
    stall_en = 1'b1;
    @(posedge clk); #1;
    cfg_count = 5'd3; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clk); #2;
      if (mgmt_write && mgmt_waitrequest) got = 1'b1;
    end
    chk("rstmid_stall_seen", 64'(got), 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rstmid_write", 64'(mgmt_write), 64'd0);
    chk("rstmid_busy",  64'(busy),       64'd0);
    chk("rstmid_done",  64'(done),       64'd0);
    chk("rstmid_error", 64'(error),      64'd0);
    rst = 1'b0;
    stall_en = 1'b0;
    run_seq("post_rst", 3, 1'b0, 92, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
